// File: rtl/sr_pulse_driver.sv
// Debounces two push-buttons and turns each press into one fixed-length active-low
// pulse on notS or notR, with a one-cycle gap between pulses and one-deep queuing.
module sr_pulse_driver #(
    parameter int DB_CYCLES = 16,
    parameter int PULSE_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_set,
    input  logic       btn_rst,
    output logic       notS,
    output logic       notR,
    output logic       busy,
    output logic [1:0] dbgState
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
    localparam logic [7:0]    PULSE_LAST = 8'(PULSE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        GAP     = 2'd3
    } stateT;

    // Index 0 is the set button, index 1 the reset button.
    logic [1:0]    btnRaw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stab;
    logic [1:0]    stabD;
    logic [1:0]    req;
    logic [CW-1:0] dbCnt [2];

    assign btnRaw = {btn_rst, btn_set};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            stab  <= '0;
            stabD <= '0;
            req   <= '0;
            for (int i = 0; i < 2; i++) begin
                dbCnt[i] <= '0;
            end
        end else begin
            sync1 <= btnRaw;
            sync2 <= sync1;
            stabD <= stab;
            // Only a debounced rising edge is a request; releases are ignored.
            req   <= stab & ~stabD;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stab[i]) begin
                    dbCnt[i] <= '0;
                end else if (dbCnt[i] == DB_LAST) begin
                    dbCnt[i] <= '0;
                    stab[i]  <= ~stab[i];
                end else begin
                    dbCnt[i] <= dbCnt[i] + 1'b1;
                end
            end
        end
    end

    logic reqS;
    logic reqR;
    assign reqS = req[0];
    assign reqR = req[1];

    stateT      state;
    stateT      stateNext;
    logic [7:0] pulseCnt;
    logic [7:0] pulseCntNext;
    logic       pendS;
    logic       pendR;
    logic       pendSNext;
    logic       pendRNext;
    logic       notSNext;
    logic       notRNext;
    logic       busyNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pulseCnt <= '0;
            pendS    <= 1'b0;
            pendR    <= 1'b0;
            notS     <= 1'b1;
            notR     <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= stateNext;
            pulseCnt <= pulseCntNext;
            pendS    <= pendSNext;
            pendR    <= pendRNext;
            notS     <= notSNext;
            notR     <= notRNext;
            busy     <= busyNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (reqS || pendS) begin
                    stateNext = PULSE_S;
                end else if (reqR || pendR) begin
                    stateNext = PULSE_R;
                end
            end
            PULSE_S, PULSE_R: begin
                if (pulseCnt == PULSE_LAST) begin
                    stateNext = GAP;
                end
            end
            GAP:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they land in flops together with it.
    always_comb begin
        pulseCntNext = '0;
        if ((stateNext == state) && ((state == PULSE_S) || (state == PULSE_R))) begin
            pulseCntNext = pulseCnt + 8'd1;
        end
        pendSNext = (pendS || reqS) && !((stateNext == PULSE_S) && (state != PULSE_S));
        pendRNext = (pendR || reqR) && !((stateNext == PULSE_R) && (state != PULSE_R));
        notSNext  = (stateNext != PULSE_S);
        notRNext  = (stateNext != PULSE_R);
        busyNext  = (stateNext != IDLE) || pendSNext || pendRNext;
    end

    assign dbgState = state;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver with DB_CYCLES=4, PULSE_LEN=3; expected output
// traces are hand-derived per cycle relative to the cycle a button is first driven.
module tb_sr_pulse_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn_set = 1'b0;
    logic       btn_rst = 1'b0;
    logic       notS;
    logic       notR;
    logic       busy;
    logic [1:0] dbgState;

    int total = 0;
    int bad = 0;

    sr_pulse_driver #(.DB_CYCLES(4), .PULSE_LEN(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_set  (btn_set),
        .btn_rst  (btn_rst),
        .notS     (notS),
        .notR     (notR),
        .busy     (busy),
        .dbgState (dbgState)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // exp = {notS, notR, busy}
    task automatic chkOut(input string tag, input logic [2:0] exp);
        chk({tag, "/notS"}, {1'b0, notS}, {1'b0, exp[2]});
        chk({tag, "/notR"}, {1'b0, notR}, {1'b0, exp[1]});
        chk({tag, "/busy"}, {1'b0, busy}, {1'b0, exp[0]});
        chk({tag, "/excl"}, {1'b0, notS | notR}, 2'b01);
    endtask

    // Single clean press from an idle FSM: pulse on edges 8..10, gap on 11.
    function automatic logic [2:0] singleExp(input int i, input bit isSet);
        if (i >= 8 && i <= 10) return isSet ? 3'b011 : 3'b101;
        if (i == 11) return 3'b111;
        return 3'b110;
    endfunction

    // Set pulse then queued reset pulse: S on 8..10, gap 11, idle-pending 12, R on 13..15, gap 16.
    function automatic logic [2:0] dualExp(input int i);
        if (i >= 8 && i <= 10) return 3'b011;
        if (i == 11 || i == 12 || i == 16) return 3'b111;
        if (i >= 13 && i <= 15) return 3'b101;
        return 3'b110;
    endfunction

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        step();
        step();
        step();
        chkOut("reset", 3'b110);
        chk("reset/state", dbgState, 2'd0);
        rst_n = 1'b1;
        step();
        chkOut("post_reset", 3'b110);

        // Clean set press, hold, then release
        btn_set = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chkOut($sformatf("clean_set[%0d]", i), singleExp(i, 1'b1));
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chkOut($sformatf("hold_set[%0d]", i), 3'b110);
        end
        btn_set = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chkOut($sformatf("release_set[%0d]", i), 3'b110);
        end
        chk("idle_state", dbgState, 2'd0);

        // Bounce on btn_rst: two cycles high, two low, for 20 cycles
        for (int i = 0; i < 20; i++) begin
            btn_rst = ((i / 2) % 2 == 0) ? 1'b1 : 1'b0;
            step();
            chkOut($sformatf("bounce[%0d]", i), 3'b110);
        end
        btn_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chkOut($sformatf("bounce_tail[%0d]", i), 3'b110);
        end

        // Simultaneous press: set wins, reset queued
        btn_set = 1'b1;
        btn_rst = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step();
            chkOut($sformatf("simul[%0d]", i), dualExp(i));
        end
        btn_set = 1'b0;
        btn_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chkOut($sformatf("simul_release[%0d]", i), 3'b110);
        end

        // Reset button pressed so its request lands during PULSE_S
        btn_set = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            if (i == 3) btn_rst = 1'b1;
            step();
            chkOut($sformatf("during_pulse[%0d]", i), dualExp(i));
        end
        btn_set = 1'b0;
        btn_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chkOut($sformatf("during_release[%0d]", i), 3'b110);
        end

        // Reset asserted in the second cycle of PULSE_R, button held throughout
        btn_rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            chkOut($sformatf("pre_reset[%0d]", i), singleExp(i, 1'b0));
        end
        rst_n = 1'b0;
        #1;
        chkOut("async_reset", 3'b110);
        chk("async_reset/state", dbgState, 2'd0);
        step();
        step();
        chkOut("held_reset", 3'b110);
        rst_n = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            chkOut($sformatf("after_reset[%0d]", i), singleExp(i, 1'b0));
        end
        btn_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chkOut($sformatf("after_reset_release[%0d]", i), 3'b110);
        end

        // A later clean press still yields exactly one pulse
        btn_set = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            chkOut($sformatf("later_set[%0d]", i), singleExp(i, 1'b1));
        end
        btn_set = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chkOut($sformatf("later_release[%0d]", i), 3'b110);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
